// File: rtl/xdn_pkg.sv
// xdn_pkg: shared widths and responder state encoding
package xdn_pkg;
   localparam int XDN_ADDRESS_WIDTH = 4;
   localparam int XDN_DATA_WIDTH    = 8;
   typedef enum logic [1:0] {RUN, LOAD, DONE} ram_state_t;
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: CPU bus, loader stream and status signals of the RAM responder (parity pins with RAM_PARITY_EN)
interface ram_responder_if #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 8
);
   logic [ADDRESS_WIDTH-1:0] i_ADDRESS;
   logic [DATA_WIDTH-1:0]    i_BUS;
   logic                     i_READ_BUS;
   logic                     i_WRITE_BUS;
   logic [DATA_WIDTH-1:0]    o_BUS;
   logic                     o_BUS_EN;
   logic                     i_PROG_MODE;
   logic                     i_PROG_VALID;
   logic [DATA_WIDTH-1:0]    i_PROG_DATA;
   logic                     o_PROG_READY;
   logic                     o_PROG_DONE;
   logic                     o_BUSY;
`ifdef RAM_PARITY_EN
   logic                     i_PARITY_INJECT;
   logic                     o_PARITY_ERR;
`endif
   modport slave (
      input  i_ADDRESS, i_BUS, i_READ_BUS, i_WRITE_BUS, i_PROG_MODE, i_PROG_VALID, i_PROG_DATA,
      output o_BUS, o_BUS_EN, o_PROG_READY, o_PROG_DONE, o_BUSY
`ifdef RAM_PARITY_EN
      , input i_PARITY_INJECT, output o_PARITY_ERR
`endif
   );
   modport master (
      output i_ADDRESS, i_BUS, i_READ_BUS, i_WRITE_BUS, i_PROG_MODE, i_PROG_VALID, i_PROG_DATA,
      input  o_BUS, o_BUS_EN, o_PROG_READY, o_PROG_DONE, o_BUSY
`ifdef RAM_PARITY_EN
      , output i_PARITY_INJECT, input o_PARITY_ERR
`endif
   );
endinterface

// File: rtl/ram_array.sv
// ram_array: unreset storage with one synchronous write port and one registered read port
module ram_array #(
   parameter int AW    = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [2**AW];
   logic [WIDTH-1:0] rdata_q;
   // write and read ports; read returns the old word on a same-address collision
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_responder.sv
// ram_responder: CPU bus memory responder with program loader; RAM_PARITY_EN adds per-word even parity
import xdn_pkg::*;
module ram_responder #(
   parameter int ADDRESS_WIDTH = XDN_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = XDN_DATA_WIDTH
) (
   input logic i_CLOCK,
   input logic i_CLEAR_N,
   ram_responder_if.slave bus
);
   localparam int DEPTH = 2**ADDRESS_WIDTH;
`ifdef RAM_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int WW = DATA_WIDTH + PW;
   ram_state_t               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d, waddr;
   logic                     bus_en_q, bus_en_d;
   logic                     cpu_ok, accept, last, we;
   logic [DATA_WIDTH-1:0]    wdata;
   logic [WW-1:0]            wword, rword;
   // next state, loader counter and CPU/loader write-port arbitration
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = (state_q == LOAD) && bus.i_PROG_VALID;
      last     = cnt_q == ADDRESS_WIDTH'(DEPTH - 1);
      cpu_ok   = (state_q == RUN) && !bus.i_PROG_MODE;
      if (!bus.i_PROG_MODE) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         state_d = LOAD;
      end else if (accept) begin
         state_d = last ? DONE : LOAD;
         cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      end
      we       = accept || (cpu_ok && bus.i_READ_BUS);
      waddr    = accept ? cnt_q : bus.i_ADDRESS;
      wdata    = accept ? bus.i_PROG_DATA : bus.i_BUS;
      bus_en_d = cpu_ok && bus.i_WRITE_BUS && !bus.i_READ_BUS;
   end
`ifdef RAM_PARITY_EN
   logic parity_err_q;
   assign wword = {^wdata ^ bus.i_PARITY_INJECT, wdata};
   // sticky flag for any presented read word with odd total parity
   always_ff @(posedge i_CLOCK or negedge i_CLEAR_N)
      if (!i_CLEAR_N) parity_err_q <= 1'b0;
      else if (bus_en_q && ^rword) parity_err_q <= 1'b1;
   assign bus.o_PARITY_ERR = parity_err_q;
`else
   assign wword = wdata;
`endif
   // state, counter and read-valid registers
   always_ff @(posedge i_CLOCK or negedge i_CLEAR_N)
      if (!i_CLEAR_N) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         bus_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bus_en_q <= bus_en_d;
      end
   ram_array #(.AW(ADDRESS_WIDTH), .WIDTH(WW)) u_array (
      .clk_i   (i_CLOCK),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wword),
      .re_i    (bus_en_d),
      .raddr_i (bus.i_ADDRESS),
      .rdata_o (rword)
   );
   assign bus.o_BUS        = bus_en_q ? rword[DATA_WIDTH-1:0] : '0;
   assign bus.o_BUS_EN     = bus_en_q;
   assign bus.o_PROG_READY = state_q == LOAD;
   assign bus.o_PROG_DONE  = state_q == DONE;
   assign bus.o_BUSY       = state_q != RUN;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder (parity checks with RAM_PARITY_EN)
module tb_ram_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] model [16];
   logic [7:0] sb [$];
   ram_responder_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) bus ();
   ram_responder dut (.i_CLOCK(clk), .i_CLEAR_N(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus.i_ADDRESS = a;
      bus.i_BUS = d;
      bus.i_READ_BUS = 1'b1;
      tick();
      bus.i_READ_BUS = 1'b0;
      model[a] = d;
   endtask

   task automatic rd(input logic [3:0] a);
      bus.i_ADDRESS = a;
      bus.i_WRITE_BUS = 1'b1;
      sb.push_back(model[a]);
      tick();
   endtask

   task automatic rd_end();
      bus.i_WRITE_BUS = 1'b0;
      tick();
   endtask

   task automatic load_word(input logic [3:0] a, input logic [7:0] d);
      bus.i_PROG_VALID = 1'b1;
      bus.i_PROG_DATA = d;
      tick();
      bus.i_PROG_VALID = 1'b0;
      model[a] = d;
   endtask

   always @(negedge clk)
      if (bus.o_BUS_EN === 1'b1) begin
         if (sb.size() == 0) check("rd_spurious", 1, 0);
         else check("rd_data", bus.o_BUS, sb.pop_front());
      end

   initial begin
      bus.i_ADDRESS = '0;
      bus.i_BUS = '0;
      bus.i_READ_BUS = 1'b0;
      bus.i_WRITE_BUS = 1'b0;
      bus.i_PROG_MODE = 1'b0;
      bus.i_PROG_VALID = 1'b0;
      bus.i_PROG_DATA = '0;
`ifdef RAM_PARITY_EN
      bus.i_PARITY_INJECT = 1'b0;
`endif
      #3;
      check("rst_bus", bus.o_BUS, 0);
      check("rst_bus_en", bus.o_BUS_EN, 0);
      check("rst_ready", bus.o_PROG_READY, 0);
      check("rst_done", bus.o_PROG_DONE, 0);
      check("rst_busy", bus.o_BUSY, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      wr(4'd3, 8'hA5);
      rd(4'd3);
      check("rd_latency", bus.o_BUS_EN, 1);
      rd_end();
      check("rd_drop_en", bus.o_BUS_EN, 0);
      check("rd_drop_bus", bus.o_BUS, 0);
      check("run_ready", bus.o_PROG_READY, 0);
      bus.i_PROG_MODE = 1'b1;
      tick();
      check("load_ready", bus.o_PROG_READY, 1);
      check("load_busy", bus.o_BUSY, 1);
      for (int i = 0; i < 16; i++) begin
         if (i % 3 == 1) begin
            bus.i_ADDRESS = 4'd0;
            bus.i_BUS = 8'hFF;
            bus.i_READ_BUS = 1'b1;
            bus.i_WRITE_BUS = 1'b1;
            tick();
            bus.i_READ_BUS = 1'b0;
            bus.i_WRITE_BUS = 1'b0;
         end
         if (i == 15) check("done_early", bus.o_PROG_DONE, 0);
         load_word(4'(i), 8'(8'h10 + i));
      end
      check("done_set", bus.o_PROG_DONE, 1);
      check("done_ready", bus.o_PROG_READY, 0);
      check("done_busy", bus.o_BUSY, 1);
      bus.i_PROG_MODE = 1'b0;
      tick();
      check("run_busy", bus.o_BUSY, 0);
      check("run_done", bus.o_PROG_DONE, 0);
      for (int a = 0; a < 16; a++) rd(4'(a));
      rd_end();
      bus.i_ADDRESS = 4'd5;
      bus.i_BUS = 8'h3C;
      bus.i_READ_BUS = 1'b1;
      bus.i_WRITE_BUS = 1'b1;
      tick();
      check("both_en", bus.o_BUS_EN, 0);
      bus.i_READ_BUS = 1'b0;
      bus.i_WRITE_BUS = 1'b0;
      model[5] = 8'h3C;
      rd(4'd5);
      rd_end();
      bus.i_PROG_MODE = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) load_word(4'(i), 8'(8'h60 + i));
      bus.i_PROG_MODE = 1'b0;
      tick();
      check("abort_busy", bus.o_BUSY, 0);
      check("abort_ready", bus.o_PROG_READY, 0);
      bus.i_PROG_MODE = 1'b1;
      tick();
      load_word(4'd0, 8'h77);
      bus.i_PROG_MODE = 1'b0;
      tick();
      for (int a = 0; a < 8; a++) rd(4'(a));
      rd_end();
      bus.i_PROG_MODE = 1'b1;
      tick();
      load_word(4'd0, 8'h90);
      load_word(4'd1, 8'h91);
      rst_n = 1'b0;
      #1;
      check("rstl_ready", bus.o_PROG_READY, 0);
      check("rstl_busy", bus.o_BUSY, 0);
      check("rstl_done", bus.o_PROG_DONE, 0);
      bus.i_PROG_MODE = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < 3; a++) rd(4'(a));
      rd_end();
      rd(4'd3);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstr_bus_en", bus.o_BUS_EN, 0);
      check("rstr_bus", bus.o_BUS, 0);
      bus.i_WRITE_BUS = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      rd(4'd3);
      rd(4'd9);
      rd_end();
`ifdef RAM_PARITY_EN
      check("par_clean", bus.o_PARITY_ERR, 0);
      bus.i_PARITY_INJECT = 1'b1;
      wr(4'd7, 8'h01);
      bus.i_PARITY_INJECT = 1'b0;
      rd(4'd7);
      rd_end();
      tick();
      check("par_err", bus.o_PARITY_ERR, 1);
      wr(4'd7, 8'h02);
      rd(4'd7);
      rd_end();
      tick();
      check("par_sticky", bus.o_PARITY_ERR, 1);
`endif
      tick();
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
